// File: rtl/reg_file_pkg.sv
// Shared defaults and flattened-port indexing helper for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_N_RD   = 2;

    // Low bit index of field 'port' inside a flattened vector of 'width'-bit fields
    function automatic int unsigned regf_slice(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regf_read_port.sv
// One registered read port: entry mux, write bypass, zero-register override, output flops.
module regf_read_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    ra,
    input  logic [DATA_W-1:0]    mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy,
    input  logic [2**ADDR_W-1:0] busy_nxt,
    input  logic                 we0,
    input  logic [ADDR_W-1:0]    wa0,
    input  logic [DATA_W-1:0]    wd0,
    input  logic                 we1,
    input  logic [ADDR_W-1:0]    wa1,
    input  logic [DATA_W-1:0]    wd1,
    output logic [DATA_W-1:0]    rd,
    output logic                 rbusy
);

    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_rd;

    // Select stored or forwarded data and the matching busy view
    always_comb begin
        hit0     = we0 && (wa0 == ra);
        hit1     = we1 && (wa1 == ra);
        data_nxt = mem[ra];
        busy_rd  = busy[ra];
        if (BYPASS) begin
            if (hit1) begin
                data_nxt = wd1;
            end else if (hit0) begin
                data_nxt = wd0;
            end
            // A forwarded write also forwards its busy clear (or a same-cycle re-reserve)
            if (hit0 || hit1) begin
                busy_rd = busy_nxt[ra];
            end
        end
        if (R0_ZERO && (ra == '0)) begin
            data_nxt = '0;
            busy_rd  = 1'b0;
        end
    end

    // Output register; reset discards any read issued in the reset cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            rbusy <= 1'b0;
        end else begin
            rd    <= data_nxt;
            rbusy <= busy_rd;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: storage, prioritised writes, busy scoreboard, N registered read ports.
module register_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned N_RD    = DEF_N_RD,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*ADDR_W-1:0] ra,
    output logic [N_RD*DATA_W-1:0] rd,
    output logic [N_RD-1:0]        rbusy,
    input  logic                   we0,
    input  logic [ADDR_W-1:0]      wa0,
    input  logic [DATA_W-1:0]      wd0,
    input  logic                   we1,
    input  logic [ADDR_W-1:0]      wa1,
    input  logic [DATA_W-1:0]      wd1,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              we0_ok;
    logic              we1_ok;
    logic              rsv_ok;

    // Drop writes and reservations aimed at the hard-wired zero entry
    always_comb begin
        we0_ok = we0;
        we1_ok = we1;
        rsv_ok = rsv_en;
        if (R0_ZERO) begin
            we0_ok = we0   && (wa0 != '0);
            we1_ok = we1   && (wa1 != '0);
            rsv_ok = rsv_en && (rsv_addr != '0);
        end
    end

    // Scoreboard update: writes clear, then a reservation (newer producer) sets
    always_comb begin
        busy_nxt = busy;
        if (we0_ok) begin
            busy_nxt[wa0] = 1'b0;
        end
        if (we1_ok) begin
            busy_nxt[wa1] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Storage; port 1 wins an address collision with port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (we0_ok && !(we1_ok && (wa1 == wa0))) begin
                mem[wa0] <= wd0;
            end
            if (we1_ok) begin
                mem[wa1] <= wd1;
            end
        end
    end

    // Read ports
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
        regf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .R0_ZERO (R0_ZERO)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .ra       (ra[regf_slice(i, ADDR_W) +: ADDR_W]),
            .mem      (mem),
            .busy     (busy),
            .busy_nxt (busy_nxt),
            .we0      (we0_ok),
            .wa0      (wa0),
            .wd0      (wd0),
            .we1      (we1_ok),
            .wa1      (wa1),
            .wd1      (wd1),
            .rd       (rd[regf_slice(i, DATA_W) +: DATA_W]),
            .rbusy    (rbusy[i])
        );
    end

endmodule
